// File: rtl/wb_csr_pkg.sv
// Shared definitions for the white-balance gain CSR block:
// register offsets, error codes and the loader FSM states.
package wb_csr_pkg;

   localparam logic [31:0] WB_R_OFFSET = 32'h0000_0000;
   localparam logic [31:0] WB_G_OFFSET = 32'h0000_0004;
   localparam logic [31:0] WB_B_OFFSET = 32'h0000_0008;

   localparam logic [1:0] AXI_OKAY = 2'b00;

   typedef enum logic [1:0] {
      WB_ERR_OK       = 2'd0,
      WB_ERR_RESP     = 2'd1,
      WB_ERR_MISMATCH = 2'd2,
      WB_ERR_TIMEOUT  = 2'd3
   } wb_err_t;

   typedef enum logic [2:0] {
      WB_IDLE,
      WB_WR_AW_W,
      WB_WR_B,
      WB_RD_AR,
      WB_RD_R,
      WB_DONE
   } wb_wr_state_t;

   function automatic logic [31:0] wb_reg_offset(input logic [1:0] idx);
      logic [31:0] off;
      case (idx)
         2'd0:    off = WB_R_OFFSET;
         2'd1:    off = WB_G_OFFSET;
         default: off = WB_B_OFFSET;
      endcase
      return off;
   endfunction

endpackage

// File: rtl/wb_coef_csr_writer.sv
// AXI4-Lite initiator that writes R/G/B white-balance gains into the
// corrector CSR block and optionally reads them back for comparison.
module wb_coef_csr_writer
   import wb_csr_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
   parameter int          COEF_WIDTH     = 12,
   parameter int          FRACT_WIDTH    = 10,
   parameter bit          VERIFY         = 1'b1,
   parameter int          TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  start_i,
   input  logic [COEF_WIDTH-1:0] gain_r_i,
   input  logic [COEF_WIDTH-1:0] gain_g_i,
   input  logic [COEF_WIDTH-1:0] gain_b_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  error_o,
   output logic [1:0]            err_code_o,
   output logic                  csr_awvalid_o,
   output logic [31:0]           csr_awaddr_o,
   output logic [2:0]            csr_awprot_o,
   input  logic                  csr_awready_i,
   output logic                  csr_wvalid_o,
   output logic [31:0]           csr_wdata_o,
   output logic [3:0]            csr_wstrb_o,
   input  logic                  csr_wready_i,
   input  logic                  csr_bvalid_i,
   input  logic [1:0]            csr_bresp_i,
   output logic                  csr_bready_o,
   output logic                  csr_arvalid_o,
   output logic [31:0]           csr_araddr_o,
   output logic [2:0]            csr_arprot_o,
   input  logic                  csr_arready_i,
   input  logic                  csr_rvalid_i,
   input  logic [31:0]           csr_rdata_i,
   input  logic [1:0]            csr_rresp_i,
   output logic                  csr_rready_o
);

   if (FRACT_WIDTH != COEF_WIDTH - 2 || TIMEOUT_CYCLES < 2
       || COEF_WIDTH >= 32) begin : g_bad_cfg
      $error("wb_coef_csr_writer: illegal parameter set");
   end

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   wb_wr_state_t          state_q, state_d;
   logic [1:0]            idx_q, idx_d;
   logic [TW-1:0]         tmo_q, tmo_d;
   logic [COEF_WIDTH-1:0] gain_r_q, gain_r_d;
   logic [COEF_WIDTH-1:0] gain_g_q, gain_g_d;
   logic [COEF_WIDTH-1:0] gain_b_q, gain_b_d;
   logic                  awvalid_q, awvalid_d;
   logic                  wvalid_q, wvalid_d;
   logic                  bready_q, bready_d;
   logic                  arvalid_q, arvalid_d;
   logic                  rready_q, rready_d;
   logic [31:0]           awaddr_q, awaddr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [31:0]           araddr_q, araddr_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  error_q, error_d;
   wb_err_t               err_q, err_d;

   logic                  fin;
   wb_err_t               fin_code;
   logic                  aw_ok, w_ok, tmo_hit;
   logic [1:0]            nxt_idx;

   function automatic logic [COEF_WIDTH-1:0] pick_gain(
      input logic [1:0]            idx,
      input logic [COEF_WIDTH-1:0] r,
      input logic [COEF_WIDTH-1:0] g,
      input logic [COEF_WIDTH-1:0] b
   );
      logic [COEF_WIDTH-1:0] v;
      case (idx)
         2'd0:    v = r;
         2'd1:    v = g;
         default: v = b;
      endcase
      return v;
   endfunction

   function automatic logic [31:0] zext(input logic [COEF_WIDTH-1:0] g);
      return {{(32-COEF_WIDTH){1'b0}}, g};
   endfunction

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      tmo_d     = tmo_q;
      gain_r_d  = gain_r_q;
      gain_g_d  = gain_g_q;
      gain_b_d  = gain_b_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      bready_d  = bready_q;
      arvalid_d = arvalid_q;
      rready_d  = rready_q;
      awaddr_d  = awaddr_q;
      wdata_d   = wdata_q;
      araddr_d  = araddr_q;
      busy_d    = busy_q;
      err_d     = err_q;
      done_d    = 1'b0;
      error_d   = 1'b0;
      fin       = 1'b0;
      fin_code  = WB_ERR_OK;
      nxt_idx   = idx_q + 2'd1;
      tmo_hit   = (tmo_q == TMO_LAST);
      aw_ok     = !awvalid_q || csr_awready_i;
      w_ok      = !wvalid_q || csr_wready_i;

      unique case (state_q)
         WB_IDLE: begin
            if (start_i) begin
               state_d   = WB_WR_AW_W;
               idx_d     = 2'd0;
               tmo_d     = '0;
               gain_r_d  = gain_r_i;
               gain_g_d  = gain_g_i;
               gain_b_d  = gain_b_i;
               awvalid_d = 1'b1;
               wvalid_d  = 1'b1;
               awaddr_d  = BASE_ADDR + wb_reg_offset(2'd0);
               wdata_d   = zext(gain_r_i);
               busy_d    = 1'b1;
               err_d     = WB_ERR_OK;
            end
         end
         WB_WR_AW_W: begin
            tmo_d = tmo_q + 1'b1;
            if (awvalid_q && csr_awready_i) awvalid_d = 1'b0;
            if (wvalid_q && csr_wready_i) wvalid_d = 1'b0;
            if (aw_ok && w_ok) begin
               state_d  = WB_WR_B;
               bready_d = 1'b1;
               tmo_d    = '0;
            end else if (tmo_hit) begin
               fin      = 1'b1;
               fin_code = WB_ERR_TIMEOUT;
            end
         end
         WB_WR_B: begin
            tmo_d = tmo_q + 1'b1;
            if (csr_bvalid_i) begin
               bready_d = 1'b0;
               if (csr_bresp_i != AXI_OKAY) begin
                  fin      = 1'b1;
                  fin_code = WB_ERR_RESP;
               end else if (idx_q != 2'd2) begin
                  state_d   = WB_WR_AW_W;
                  idx_d     = nxt_idx;
                  tmo_d     = '0;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  awaddr_d  = BASE_ADDR + wb_reg_offset(nxt_idx);
                  wdata_d   = zext(pick_gain(nxt_idx, gain_r_q,
                                             gain_g_q, gain_b_q));
               end else if (VERIFY) begin
                  state_d   = WB_RD_AR;
                  idx_d     = 2'd0;
                  tmo_d     = '0;
                  arvalid_d = 1'b1;
                  araddr_d  = BASE_ADDR + wb_reg_offset(2'd0);
               end else begin
                  fin = 1'b1;
               end
            end else if (tmo_hit) begin
               fin      = 1'b1;
               fin_code = WB_ERR_TIMEOUT;
            end
         end
         WB_RD_AR: begin
            tmo_d = tmo_q + 1'b1;
            if (csr_arready_i) begin
               state_d   = WB_RD_R;
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               tmo_d     = '0;
            end else if (tmo_hit) begin
               fin      = 1'b1;
               fin_code = WB_ERR_TIMEOUT;
            end
         end
         WB_RD_R: begin
            tmo_d = tmo_q + 1'b1;
            if (csr_rvalid_i) begin
               rready_d = 1'b0;
               if (csr_rresp_i != AXI_OKAY) begin
                  fin      = 1'b1;
                  fin_code = WB_ERR_RESP;
               end else if (csr_rdata_i[COEF_WIDTH-1:0] !=
                            pick_gain(idx_q, gain_r_q, gain_g_q, gain_b_q)) begin
                  fin      = 1'b1;
                  fin_code = WB_ERR_MISMATCH;
               end else if (idx_q != 2'd2) begin
                  state_d   = WB_RD_AR;
                  idx_d     = nxt_idx;
                  tmo_d     = '0;
                  arvalid_d = 1'b1;
                  araddr_d  = BASE_ADDR + wb_reg_offset(nxt_idx);
               end else begin
                  fin = 1'b1;
               end
            end else if (tmo_hit) begin
               fin      = 1'b1;
               fin_code = WB_ERR_TIMEOUT;
            end
         end
         WB_DONE: begin
            state_d = WB_IDLE;
            busy_d  = 1'b0;
         end
         default: state_d = WB_IDLE;
      endcase

      // Every termination path, including timeout, releases the bus at once.
      if (fin) begin
         state_d   = WB_DONE;
         done_d    = 1'b1;
         error_d   = (fin_code != WB_ERR_OK);
         err_d     = fin_code;
         awvalid_d = 1'b0;
         wvalid_d  = 1'b0;
         bready_d  = 1'b0;
         arvalid_d = 1'b0;
         rready_d  = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= WB_IDLE;
         idx_q     <= '0;
         tmo_q     <= '0;
         gain_r_q  <= '0;
         gain_g_q  <= '0;
         gain_b_q  <= '0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         araddr_q  <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
         err_q     <= WB_ERR_OK;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         tmo_q     <= tmo_d;
         gain_r_q  <= gain_r_d;
         gain_g_q  <= gain_g_d;
         gain_b_q  <= gain_b_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         bready_q  <= bready_d;
         arvalid_q <= arvalid_d;
         rready_q  <= rready_d;
         awaddr_q  <= awaddr_d;
         wdata_q   <= wdata_d;
         araddr_q  <= araddr_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         error_q   <= error_d;
         err_q     <= err_d;
      end
   end

   logic unused_rdata;
   assign unused_rdata = &{1'b0, csr_rdata_i[31:COEF_WIDTH]};

   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign error_o       = error_q;
   assign err_code_o    = err_q;
   assign csr_awvalid_o = awvalid_q;
   assign csr_awaddr_o  = awaddr_q;
   assign csr_awprot_o  = 3'b000;
   assign csr_wvalid_o  = wvalid_q;
   assign csr_wdata_o   = wdata_q;
   assign csr_wstrb_o   = 4'hF;
   assign csr_bready_o  = bready_q;
   assign csr_arvalid_o = arvalid_q;
   assign csr_araddr_o  = araddr_q;
   assign csr_arprot_o  = 3'b000;
   assign csr_rready_o  = rready_q;

endmodule

// File: tb/tb_wb_coef_csr_writer.sv
// Directed bench for wb_coef_csr_writer with a small AXI4-Lite
// slave whose ready delays, error responses and read data are tunable.
module tb_wb_coef_csr_writer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        start_i;
   logic [11:0] gain_r, gain_g, gain_b;
   logic        busy_o, done_o, error_o;
   logic [1:0]  err_code_o;
   logic        csr_awvalid_o, csr_awready;
   logic [31:0] csr_awaddr_o;
   logic [2:0]  csr_awprot_o;
   logic        csr_wvalid_o, csr_wready;
   logic [31:0] csr_wdata_o;
   logic [3:0]  csr_wstrb_o;
   logic        csr_bvalid, csr_bready_o;
   logic [1:0]  csr_bresp;
   logic        csr_arvalid_o, csr_arready;
   logic [31:0] csr_araddr_o;
   logic [2:0]  csr_arprot_o;
   logic        csr_rvalid, csr_rready_o;
   logic [31:0] csr_rdata;
   logic [1:0]  csr_rresp;

   wb_coef_csr_writer #(
      .BASE_ADDR      (32'h0000_0000),
      .COEF_WIDTH     (12),
      .FRACT_WIDTH    (10),
      .VERIFY         (1'b1),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk_i         (clk),
      .rst_n_i       (rst_n),
      .start_i       (start_i),
      .gain_r_i      (gain_r),
      .gain_g_i      (gain_g),
      .gain_b_i      (gain_b),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .error_o       (error_o),
      .err_code_o    (err_code_o),
      .csr_awvalid_o (csr_awvalid_o),
      .csr_awaddr_o  (csr_awaddr_o),
      .csr_awprot_o  (csr_awprot_o),
      .csr_awready_i (csr_awready),
      .csr_wvalid_o  (csr_wvalid_o),
      .csr_wdata_o   (csr_wdata_o),
      .csr_wstrb_o   (csr_wstrb_o),
      .csr_wready_i  (csr_wready),
      .csr_bvalid_i  (csr_bvalid),
      .csr_bresp_i   (csr_bresp),
      .csr_bready_o  (csr_bready_o),
      .csr_arvalid_o (csr_arvalid_o),
      .csr_araddr_o  (csr_araddr_o),
      .csr_arprot_o  (csr_arprot_o),
      .csr_arready_i (csr_arready),
      .csr_rvalid_i  (csr_rvalid),
      .csr_rdata_i   (csr_rdata),
      .csr_rresp_i   (csr_rresp),
      .csr_rready_o  (csr_rready_o)
   );

   // slave knobs
   int          aw_delay = 0;
   int          w_delay  = 0;
   logic        b_en     = 1'b1;
   logic [31:0] err_addr = 32'hFFFF_FFFF;
   logic [31:0] bad_addr = 32'hFFFF_FFFF;

   int          aw_wait, w_wait;
   logic        aw_got, w_got;
   logic [31:0] aw_a, w_d;
   logic [31:0] mem [4];
   logic        aw_hs, w_hs, wr_fire;
   logic [31:0] wr_addr, wr_data;

   assign csr_awready = (aw_wait >= aw_delay);
   assign csr_wready  = (w_wait >= w_delay);
   assign csr_arready = 1'b1;
   assign aw_hs   = csr_awvalid_o && csr_awready;
   assign w_hs    = csr_wvalid_o && csr_wready;
   assign wr_fire = (aw_got || aw_hs) && (w_got || w_hs);
   assign wr_addr = aw_hs ? csr_awaddr_o : aw_a;
   assign wr_data = w_hs ? csr_wdata_o : w_d;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aw_wait    <= 0;
         w_wait     <= 0;
         aw_got     <= 1'b0;
         w_got      <= 1'b0;
         aw_a       <= '0;
         w_d        <= '0;
         csr_bvalid <= 1'b0;
         csr_bresp  <= 2'b00;
         csr_rvalid <= 1'b0;
         csr_rdata  <= '0;
         csr_rresp  <= 2'b00;
         for (int i = 0; i < 4; i++) mem[i] <= '0;
      end else begin
         if (aw_hs) aw_wait <= 0;
         else if (csr_awvalid_o) aw_wait <= aw_wait + 1;
         if (w_hs) w_wait <= 0;
         else if (csr_wvalid_o) w_wait <= w_wait + 1;
         if (aw_hs) begin
            aw_got <= 1'b1;
            aw_a   <= csr_awaddr_o;
         end
         if (w_hs) begin
            w_got <= 1'b1;
            w_d   <= csr_wdata_o;
         end
         if (csr_bvalid && csr_bready_o) csr_bvalid <= 1'b0;
         if (wr_fire) begin
            aw_got <= 1'b0;
            w_got  <= 1'b0;
            mem[wr_addr[3:2]] <= wr_data;
            if (b_en) begin
               csr_bvalid <= 1'b1;
               csr_bresp  <= (wr_addr == err_addr) ? 2'b10 : 2'b00;
            end
         end
         if (csr_rvalid && csr_rready_o) csr_rvalid <= 1'b0;
         if (csr_arvalid_o && csr_arready) begin
            csr_rvalid <= 1'b1;
            csr_rresp  <= 2'b00;
            csr_rdata  <= mem[csr_araddr_o[3:2]]
                          + ((csr_araddr_o == bad_addr) ? 32'd1 : 32'd0);
         end
      end
   end

   // bus monitor
   int          cyc = 0;
   int          aw_n = 0, w_n = 0, ar_n = 0;
   int          done_n = 0, err_n = 0, br_n = 0, split_n = 0;
   int          start_edge = 0, done_at = 0;
   logic [31:0] aw_log [64];
   logic [31:0] w_log  [64];
   logic [31:0] ar_log [64];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (aw_hs) begin
         aw_log[aw_n] <= csr_awaddr_o;
         aw_n <= aw_n + 1;
      end
      if (w_hs) begin
         w_log[w_n] <= csr_wdata_o;
         w_n <= w_n + 1;
      end
      if (csr_arvalid_o && csr_arready) begin
         ar_log[ar_n] <= csr_araddr_o;
         ar_n <= ar_n + 1;
      end
      if (start_i && !busy_o && rst_n) start_edge <= cyc;
      if (done_o) begin
         done_n  <= done_n + 1;
         done_at <= cyc;
      end
      if (error_o) err_n <= err_n + 1;
      if (csr_bready_o) br_n <= br_n + 1;
      if (csr_awvalid_o && !csr_wvalid_o) split_n <= split_n + 1;
   end

   int errors = 0;
   int checks = 0;
   int aw0, w0, ar0, dn0, er0, br0, sp0;
   logic [11:0] exp_g [3];

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic snap();
      aw0 = aw_n; w0 = w_n; ar0 = ar_n;
      dn0 = done_n; er0 = err_n; br0 = br_n; sp0 = split_n;
   endtask

   task automatic pulse_start(input logic [11:0] r, input logic [11:0] g,
                              input logic [11:0] b);
      @(negedge clk);
      gain_r = r; gain_g = g; gain_b = b;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
   endtask

   task automatic wait_done(input int limit);
      for (int i = 0; i < limit && done_n == dn0; i++) @(negedge clk);
      repeat (6) @(negedge clk);
   endtask

   task automatic chk_logs(input string tag, input int n_aw, input int n_ar);
      for (int i = 0; i < n_aw; i++) begin
         chk($sformatf("%s_awaddr%0d", tag, i), aw_log[aw0+i], 32'(4*i));
         chk($sformatf("%s_wdata%0d", tag, i), w_log[w0+i], 32'(exp_g[i]));
      end
      for (int i = 0; i < n_ar; i++)
         chk($sformatf("%s_araddr%0d", tag, i), ar_log[ar0+i], 32'(4*i));
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_g[0] = 12'h400; exp_g[1] = 12'h380; exp_g[2] = 12'h5A0;
      rst_n = 1'b0; start_i = 1'b0;
      gain_r = '0; gain_g = '0; gain_b = '0;
      repeat (3) @(negedge clk);

      // reset state
      chk("rst_awvalid", 32'(csr_awvalid_o), 0);
      chk("rst_wvalid", 32'(csr_wvalid_o), 0);
      chk("rst_bready", 32'(csr_bready_o), 0);
      chk("rst_arvalid", 32'(csr_arvalid_o), 0);
      chk("rst_rready", 32'(csr_rready_o), 0);
      chk("rst_busy", 32'(busy_o), 0);
      chk("rst_done", 32'(done_o), 0);
      chk("rst_error", 32'(error_o), 0);
      chk("rst_errcode", 32'(err_code_o), 0);
      chk("rst_awaddr", csr_awaddr_o, 0);
      chk("rst_wdata", csr_wdata_o, 0);
      chk("rst_araddr", csr_araddr_o, 0);
      chk("rst_wstrb", 32'(csr_wstrb_o), 32'hF);
      chk("rst_prot", 32'({csr_awprot_o, csr_arprot_o}), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // 1: nominal load with read-back
      snap();
      pulse_start(12'h400, 12'h380, 12'h5A0);
      chk("t1_busy", 32'(busy_o), 1);
      wait_done(100);
      chk("t1_aw_cnt", 32'(aw_n - aw0), 3);
      chk("t1_ar_cnt", 32'(ar_n - ar0), 3);
      chk_logs("t1", 3, 3);
      chk("t1_done_cnt", 32'(done_n - dn0), 1);
      chk("t1_done_cycle", 32'(done_at - start_edge), 13);
      chk("t1_err_cnt", 32'(err_n - er0), 0);
      chk("t1_errcode", 32'(err_code_o), 0);
      chk("t1_busy_end", 32'(busy_o), 0);

      // 2: slow aw/w readies, channels complete independently
      aw_delay = 3; w_delay = 1;
      snap();
      pulse_start(12'h400, 12'h380, 12'h5A0);
      wait_done(200);
      chk("t2_split_cycles", 32'(split_n - sp0), 6);
      chk("t2_aw_cnt", 32'(aw_n - aw0), 3);
      chk_logs("t2", 3, 3);
      chk("t2_done_cnt", 32'(done_n - dn0), 1);
      chk("t2_errcode", 32'(err_code_o), 0);
      aw_delay = 0; w_delay = 0;

      // 3: SLVERR on the green write aborts the load
      err_addr = 32'h4;
      snap();
      pulse_start(12'h400, 12'h380, 12'h5A0);
      wait_done(100);
      chk("t3_aw_cnt", 32'(aw_n - aw0), 2);
      chk("t3_ar_cnt", 32'(ar_n - ar0), 0);
      chk("t3_done_cnt", 32'(done_n - dn0), 1);
      chk("t3_err_cnt", 32'(err_n - er0), 1);
      chk("t3_errcode", 32'(err_code_o), 1);
      err_addr = 32'hFFFF_FFFF;

      // 4: corrupted green read-back
      bad_addr = 32'h4;
      snap();
      pulse_start(12'h400, 12'h380, 12'h5A0);
      wait_done(100);
      chk("t4_aw_cnt", 32'(aw_n - aw0), 3);
      chk("t4_ar_cnt", 32'(ar_n - ar0), 2);
      chk_logs("t4", 3, 2);
      chk("t4_err_cnt", 32'(err_n - er0), 1);
      chk("t4_errcode", 32'(err_code_o), 2);
      bad_addr = 32'hFFFF_FFFF;

      // 5: write response never arrives
      b_en = 1'b0;
      snap();
      pulse_start(12'h123, 12'h456, 12'h789);
      wait_done(100);
      chk("t5_bready_cycles", 32'(br_n - br0), 16);
      chk("t5_bready_low", 32'(csr_bready_o), 0);
      chk("t5_aw_cnt", 32'(aw_n - aw0), 1);
      chk("t5_done_cnt", 32'(done_n - dn0), 1);
      chk("t5_err_cnt", 32'(err_n - er0), 1);
      chk("t5_errcode", 32'(err_code_o), 3);
      b_en = 1'b1;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // 6: start while busy is dropped
      snap();
      pulse_start(12'h400, 12'h380, 12'h5A0);
      repeat (3) @(negedge clk);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      wait_done(100);
      repeat (20) @(negedge clk);
      chk("t6_done_cnt", 32'(done_n - dn0), 1);
      chk("t6_aw_cnt", 32'(aw_n - aw0), 3);
      chk("t6_errcode", 32'(err_code_o), 0);

      // 7: asynchronous reset during a read data phase
      snap();
      pulse_start(12'h400, 12'h380, 12'h5A0);
      for (int i = 0; i < 100 && !csr_rready_o; i++) @(negedge clk);
      chk("t7_in_rd_r", 32'(csr_rready_o), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t7_async_valids",
          32'({csr_awvalid_o, csr_wvalid_o, csr_bready_o,
               csr_arvalid_o, csr_rready_o}), 0);
      chk("t7_async_busy", 32'(busy_o), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("t7_idle_busy", 32'(busy_o), 0);
      chk("t7_done_lost", 32'(done_n - dn0), 0);
      chk("t7_errcode", 32'(err_code_o), 0);
      snap();
      pulse_start(12'h400, 12'h380, 12'h5A0);
      wait_done(100);
      chk("t7_recover_done", 32'(done_n - dn0), 1);
      chk("t7_recover_ar", 32'(ar_n - ar0), 3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/wb_coef_csr_writer.md
# wb_coef_csr_writer

AXI4-Lite initiator that loads red/green/blue white-balance gains into the white-balance corrector's CSR block. On a start request it issues three register writes and, when enabled, reads each register back and compares it with the value written. It sits between a gain source (software mailbox or AWB estimator) and the corrector's CSR slave port, and drives the opposite end of the same `csr_*` bus.

## Interface
- `BASE_ADDR`, 32'h0000_0000, corrector CSR base address.
- `COEF_WIDTH`, 12, gain width: unsigned, 2 integer bits + `FRACT_WIDTH` fraction bits.
- `FRACT_WIDTH`, 10, fraction bits; must equal `COEF_WIDTH` - 2.
- `VERIFY`, 1, 1 = read back and compare all three registers after the writes.
- `TIMEOUT_CYCLES`, 1024, wait-cycle limit per transaction; must be >= 2.

- `clk_i` in 1: single clock.
- `rst_n_i` in 1: reset, asynchronous, active-low.
- `start_i` in 1: request a gain load; sampled only in IDLE.
- `gain_r_i`, `gain_g_i`, `gain_b_i` in `COEF_WIDTH` each: gains, captured on start accept.
- `busy_o` out 1: high from the cycle after accept until DONE is left.
- `done_o` out 1: one-cycle pulse at the end of every accepted load.
- `error_o` out 1: one-cycle pulse coincident with `done_o` when the load failed.
- `err_code_o` out 2: 0 = OK, 1 = bresp/rresp not OKAY, 2 = read-back mismatch, 3 = timeout. Held until the next accept.
- `csr_awvalid_o` out 1, `csr_awaddr_o` out 32, `csr_awprot_o` out 3 (always 3'b000), `csr_awready_i` in 1.
- `csr_wvalid_o` out 1, `csr_wdata_o` out 32, `csr_wstrb_o` out 4 (always 4'hF), `csr_wready_i` in 1.
- `csr_bvalid_i` in 1, `csr_bresp_i` in 2, `csr_bready_o` out 1.
- `csr_arvalid_o` out 1, `csr_araddr_o` out 32, `csr_arprot_o` out 3 (always 3'b000), `csr_arready_i` in 1.
- `csr_rvalid_i` in 1, `csr_rdata_i` in 32, `csr_rresp_i` in 2, `csr_rready_o` out 1.

## Operation
- Register map, relative to `BASE_ADDR`: 0x00 red, 0x04 green, 0x08 blue.
- Write data is the gain zero-extended to 32 bits.
- The read comparison uses `rdata[COEF_WIDTH-1:0]` only; upper bits are ignored.
- States and transitions:
  - IDLE -> WR_AW_W on `start_i`. A 2-bit index is set to 0 and the three gains are registered.
  - WR_AW_W: `awvalid` and `wvalid` are raised together. Each is dropped independently on its own handshake. Leave for WR_B once both channels have completed.
  - WR_B: `bready` = 1. On the `bvalid` handshake:
    - bresp != 0 -> DONE, code 1.
    - else index < 2 -> index+1, back to WR_AW_W.
    - else -> RD_AR if `VERIFY`, otherwise DONE.
  - RD_AR: `arvalid` = 1 until the `arready` handshake -> RD_R. The index restarts at 0 on entry from WR_B.
  - RD_R: `rready` = 1. On the `rvalid` handshake:
    - rresp != 0 -> DONE, code 1.
    - data mismatch -> DONE, code 2.
    - else index < 2 -> index+1, back to RD_AR.
    - else -> DONE.
  - DONE: `done_o` = 1 (and `error_o` if code != 0) for one cycle, then -> IDLE.
- Any error aborts the remaining transactions.
- Timeout counter:
  - Cleared on entry to WR_AW_W, WR_B, RD_AR and RD_R.
  - Increments every cycle in those states.
  - Reaching `TIMEOUT_CYCLES` -> DONE, code 3, all valid/ready outputs dropped in the same edge.
  - This deliberately breaks AXI valid-hold toward a hung slave; that slave must be reset before it is reused.
- `start_i` high while busy is ignored and not queued.
- Async reset mid-transaction:
  - All `*valid_o`/`*ready_o` go 0 immediately.
  - State returns to IDLE; a pending `done_o` is lost.

## Timing
- Reset values: all valid/ready = 0, `busy_o` = 0, `done_o` = 0, `error_o` = 0, `err_code_o` = 0, addresses/data = 0.
- All outputs are registered; there is no combinational path from input to output.
- Cycle numbering: start accepted at edge 0. Slave model: ready always high, response one cycle after the address handshake.
  - Write n occupies cycles 2n+1 (aw/w) and 2n+2 (b).
  - Reads occupy cycles 7–12.
  - `done_o` is high in cycle 13 with `VERIFY`=1, or in cycle 7 with `VERIFY`=0.
- `awvalid`/`wvalid` may complete in different cycles; WR_B is entered the cycle after the later of the two handshakes.

## Structure
- Package `wb_csr_pkg` holds:
  - Register offset constants `WB_R_OFFSET`, `WB_G_OFFSET`, `WB_B_OFFSET`.
  - Enum `wb_err_t` (OK, RESP, MISMATCH, TIMEOUT).
  - State enum `wb_wr_state_t`.
- The corrector CSR block imports the same offset constants.
- Single module with no sub-modules: one FSM plus the index and timeout counters.

## Test plan
- Gains 0x400/0x380/0x5A0, always-ready OKAY slave with `VERIFY`=1:
  - AW addresses BASE+0/4/8 with data 0x400/0x380/0x5A0.
  - Three reads to the same addresses.
  - `done_o` in cycle 13, `err_code_o`=0.
- Slave with `awready` delayed 3 cycles and `wready` delayed 1 cycle:
  - `wvalid` drops after its own handshake while `awvalid` stays high.
  - Writes complete correctly; `done_o` pulses once.
- Slave returns SLVERR on the second write:
  - No third write and no reads are issued.
  - `error_o`=`done_o`=1, `err_code_o`=1.
- Slave memory corrupts green (returns 0x381):
  - All three writes complete.
  - The abort occurs at read 2; the blue read is not issued; `err_code_o`=2.
- `TIMEOUT_CYCLES`=16 with `bvalid` never asserted: `bready` drops after 16 cycles in WR_B, `err_code_o`=3.
- Additional checks:
  - `start_i` pulsed during busy -> exactly one `done_o`.
  - `rst_n_i` asserted while in RD_R -> all valids 0 asynchronously; IDLE after release.
